// File: rtl/cpu_pkg.sv
// Shared processor definitions: address width default, reset address and the
// stack operation code used by the decoder and the return-address stack.
package cpu_pkg;

   localparam int CPU_AW = 8;
   localparam logic [CPU_AW-1:0] RESET_ADDR = 8'h00;

   typedef enum logic [1:0] {
      NOP     = 2'd0,
      PUSH    = 2'd1,
      POP     = 2'd2,
      REPLACE = 2'd3
   } stack_op_t;

endpackage

// File: rtl/rtn_stack_mem.sv
// DEPTH x AW register array for the return-address stack: one write port and
// one combinational read port. Contents are intentionally not reset.
module rtn_stack_mem #(
   parameter int DEPTH = 8,
   parameter int AW    = 8
) (
   input  logic                     clk,
   input  logic                     i_we,
   input  logic [$clog2(DEPTH)-1:0] i_wr_idx,
   input  logic [AW-1:0]            i_wr_data,
   input  logic [$clog2(DEPTH)-1:0] i_rd_idx,
   output logic [AW-1:0]            o_rd_data
);

   logic [AW-1:0] r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_wr_idx] <= i_wr_data;
      end
   end

   // Non-power-of-two depths leave index codes with no backing entry.
   assign o_rd_data = (int'(i_rd_idx) < DEPTH) ? r_mem[i_rd_idx] : '0;

endmodule

// File: rtl/rtn_addr_stack.sv
// Return-address stack: push captures pc+1 on a call, pop exposes the next
// saved address. The top of stack is held in its own register for the PC.
module rtn_addr_stack
   import cpu_pkg::*;
#(
   parameter int DEPTH = 8,
   parameter int AW    = CPU_AW
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [AW-1:0]              pc,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clr_err,
   output logic [AW-1:0]              return_addr,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH+1)-1:0] depth,
   output logic                       ovf_err,
   output logic                       unf_err
);

   localparam int SPW = $clog2(DEPTH+1);
   localparam int IW  = $clog2(DEPTH);

   logic [SPW-1:0] r_sp;
   logic [AW-1:0]  r_top;
   logic           r_ovf;
   logic           r_unf;

   stack_op_t      w_op;
   logic           w_ovf;
   logic           w_unf;
   logic           w_empty;
   logic           w_full;
   logic [AW-1:0]  w_push_val;
   logic           w_we;
   logic [IW-1:0]  w_wr_idx;
   logic [IW-1:0]  w_rd_idx;
   logic [AW-1:0]  w_rd_data;

   assign w_empty    = (r_sp == '0);
   assign w_full     = (r_sp == SPW'(DEPTH));
   assign w_push_val = pc + AW'(1);

   // A push+pop on an empty stack still writes, but is a return with nothing saved.
   always_comb begin
      w_op  = NOP;
      w_ovf = 1'b0;
      w_unf = 1'b0;
      unique case ({push, pop})
         2'b10: begin
            if (w_full) w_ovf = 1'b1;
            else        w_op  = PUSH;
         end
         2'b01: begin
            if (w_empty) w_unf = 1'b1;
            else         w_op  = POP;
         end
         2'b11: begin
            if (w_empty) begin
               w_op  = PUSH;
               w_unf = 1'b1;
            end else begin
               w_op  = REPLACE;
            end
         end
         default: ;
      endcase
   end

   assign w_we     = (w_op == PUSH) || (w_op == REPLACE);
   assign w_wr_idx = (w_op == PUSH) ? IW'(r_sp) : IW'(r_sp - SPW'(1));
   assign w_rd_idx = IW'(r_sp - SPW'(2));

   rtn_stack_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk       (clk),
      .i_we      (w_we),
      .i_wr_idx  (w_wr_idx),
      .i_wr_data (w_push_val),
      .i_rd_idx  (w_rd_idx),
      .o_rd_data (w_rd_data)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sp  <= '0;
         r_top <= AW'(RESET_ADDR);
         r_ovf <= 1'b0;
         r_unf <= 1'b0;
      end else begin
         unique case (w_op)
            PUSH: begin
               r_sp  <= r_sp + SPW'(1);
               r_top <= w_push_val;
            end
            REPLACE: r_top <= w_push_val;
            POP: begin
               r_sp  <= r_sp - SPW'(1);
               r_top <= (r_sp == SPW'(1)) ? '0 : w_rd_data;
            end
            default: ;
         endcase
         // A new error in the same cycle as the clear leaves the flag set.
         if (w_ovf)        r_ovf <= 1'b1;
         else if (clr_err) r_ovf <= 1'b0;
         if (w_unf)        r_unf <= 1'b1;
         else if (clr_err) r_unf <= 1'b0;
      end
   end

   assign return_addr = r_top;
   assign empty       = w_empty;
   assign full        = w_full;
   assign depth       = r_sp;
   assign ovf_err     = r_ovf;
   assign unf_err     = r_unf;

endmodule

// File: tb/tb_rtn_addr_stack.sv
// Self-checking bench for rtn_addr_stack: directed scenarios followed by random
// call/return traffic, checked against a queue-based stack model.
module tb_rtn_addr_stack;

   localparam int DEPTH = 8;
   localparam int AW    = 8;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic [AW-1:0] pc = '0;
   logic          push = 1'b0;
   logic          pop = 1'b0;
   logic          clr_err = 1'b0;
   logic [AW-1:0] return_addr;
   logic          empty;
   logic          full;
   logic [3:0]    depth;
   logic          ovf_err;
   logic          unf_err;

   int n_assert = 0;
   int n_fail   = 0;

   logic [AW-1:0] stk[$];
   logic          m_ovf = 1'b0;
   logic          m_unf = 1'b0;

   rtn_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
      .clk         (clk),
      .reset       (reset),
      .pc          (pc),
      .push        (push),
      .pop         (pop),
      .clr_err     (clr_err),
      .return_addr (return_addr),
      .empty       (empty),
      .full        (full),
      .depth       (depth),
      .ovf_err     (ovf_err),
      .unf_err     (unf_err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      stk.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
   endtask

   // Stack semantics from the call/return rules, independent of any pointer scheme.
   task automatic model_update(input logic ps, input logic pp, input logic [AW-1:0] p, input logic clr);
      logic          e_ovf;
      logic          e_unf;
      logic [AW-1:0] v;
      e_ovf = 1'b0;
      e_unf = 1'b0;
      v = AW'((int'(p) + 1) % 256);
      if (ps && pp) begin
         if (stk.size() == 0) begin
            stk.push_back(v);
            e_unf = 1'b1;
         end else begin
            stk[stk.size()-1] = v;
         end
      end else if (ps) begin
         if (stk.size() == DEPTH) e_ovf = 1'b1;
         else stk.push_back(v);
      end else if (pp) begin
         if (stk.size() == 0) e_unf = 1'b1;
         else void'(stk.pop_back());
      end
      m_ovf = e_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = e_unf ? 1'b1 : (clr ? 1'b0 : m_unf);
   endtask

   task automatic check_all(input string tag);
      logic [AW-1:0] exp_ret;
      exp_ret = (stk.size() == 0) ? '0 : stk[stk.size()-1];
      check({tag, ".ret"},   32'(return_addr), 32'(exp_ret));
      check({tag, ".depth"}, 32'(depth),       32'(stk.size()));
      check({tag, ".empty"}, 32'(empty),       32'(stk.size() == 0));
      check({tag, ".full"},  32'(full),        32'(stk.size() == DEPTH));
      check({tag, ".ovf"},   32'(ovf_err),     32'(m_ovf));
      check({tag, ".unf"},   32'(unf_err),     32'(m_unf));
   endtask

   task automatic step(input string tag, input logic ps, input logic pp,
                       input logic [AW-1:0] p, input logic clr);
      push    = ps;
      pop     = pp;
      pc      = p;
      clr_err = clr;
      @(posedge clk);
      model_update(ps, pp, p, clr);
      #1;
      push    = 1'b0;
      pop     = 1'b0;
      clr_err = 1'b0;
      check_all(tag);
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, ".ret"},   32'(return_addr), 32'h0);
      check({tag, ".depth"}, 32'(depth),       32'h0);
      check({tag, ".empty"}, 32'(empty),       32'h1);
      check({tag, ".full"},  32'(full),        32'h0);
      check({tag, ".ovf"},   32'(ovf_err),     32'h0);
      check({tag, ".unf"},   32'(unf_err),     32'h0);
   endtask

   initial begin
      #1 reset = 1'b1;
      #2 check_reset_vals("rst0");
      model_clear();
      #10 reset = 1'b0;

      step("push10", 1, 0, 8'h10, 0);
      check("push10.const", 32'(return_addr), 32'h11);
      step("pop1", 0, 1, 8'h00, 0);
      check("pop1.const_empty", 32'(empty), 32'h1);

      step("p20", 1, 0, 8'h20, 0);
      step("p30", 1, 0, 8'h30, 0);
      step("p40", 1, 0, 8'h40, 0);
      step("q1", 0, 1, 8'h00, 0);
      check("q1.const", 32'(return_addr), 32'h31);
      step("q2", 0, 1, 8'h00, 0);
      check("q2.const", 32'(return_addr), 32'h21);
      step("q3", 0, 1, 8'h00, 0);
      check("q3.const", 32'(return_addr), 32'h00);

      for (int i = 0; i < DEPTH; i++) step($sformatf("fill%0d", i), 1, 0, AW'(8'h60 + i), 0);
      check("fill.const_full", 32'(full), 32'h1);
      step("ovf", 1, 0, 8'hAA, 0);
      check("ovf.const_top", 32'(return_addr), 32'h68);
      check("ovf.const_flag", 32'(ovf_err), 32'h1);
      step("clr", 0, 0, 8'h00, 1);
      step("fullrep", 1, 1, 8'h7E, 0);
      check("fullrep.const_ovf", 32'(ovf_err), 32'h0);
      step("ovf_clr", 1, 0, 8'h11, 1);
      check("ovf_clr.const_setwins", 32'(ovf_err), 32'h1);

      for (int i = 0; i < DEPTH; i++) step($sformatf("drain%0d", i), 0, 1, 8'h00, 0);
      step("unf", 0, 1, 8'h00, 1);
      check("unf.const", 32'(unf_err), 32'h1);
      step("clr2", 0, 0, 8'h00, 1);
      step("pp_empty", 1, 1, 8'h05, 0);
      check("pp_empty.const_ret", 32'(return_addr), 32'h06);
      check("pp_empty.const_unf", 32'(unf_err), 32'h1);

      step("wrap", 1, 0, 8'hFF, 0);
      check("wrap.const", 32'(return_addr), 32'h00);
      step("tail", 1, 1, 8'h50, 0);
      check("tail.const_ret", 32'(return_addr), 32'h51);
      check("tail.const_depth", 32'(depth), 32'h2);

      step("r1", 1, 0, 8'h01, 0);
      step("r2", 1, 0, 8'h02, 0);
      step("r3", 1, 0, 8'h03, 0);
      #3 reset = 1'b1;
      #1 check_reset_vals("async_rst");
      model_clear();
      #2 reset = 1'b0;
      step("pop_after_rst", 0, 1, 8'h00, 0);
      check("pop_after_rst.const", 32'(unf_err), 32'h1);

      for (int i = 0; i < 400; i++) begin
         logic ps, pp, clr;
         logic [AW-1:0] p;
         int r;
         r   = int'($urandom_range(0, 9));
         ps  = (r < 5) || (r == 9);
         pp  = (r >= 5);
         clr = ($urandom_range(0, 7) == 0);
         p   = AW'($urandom);
         step($sformatf("rnd%0d", i), ps, pp, p, clr);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
